network_input_loader: RTL and testbench

Front-end producer for the `neural_network` input port. It accepts fixed-point feature samples one per handshake from a streaming source and assembles them into the parallel `inputs` vector. Once the vector is complete it drives a single-cycle `inputs_ready` strobe, then holds the vector stable and blocks the source until the network returns `outputs_ready`. It sits between the sample source (DMA/UART deserialiser) and the first dense layer.

---
 rtl/nn_pkg.sv | 18 +
 rtl/network_input_loader.sv | 135 +++++++++++++
 tb/tb_network_input_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : nn_pkg                                                    |
// | Purpose  : Fixed-point sample type shared by the network blocks.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package nn_pkg;

    localparam int INTG_WIDTH = 16;
    localparam int FRAC_WIDTH = 16;

    typedef struct packed {
        logic signed [INTG_WIDTH-1:0] intg;
        logic        [FRAC_WIDTH-1:0] frac;
    } fixed;

endpackage
`default_nettype wire

// File: rtl/network_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : network_input_loader                                      |
// | Purpose  : Collects streamed samples into the network input vector,  |
// |            fires it once and blocks the source until completion.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module network_input_loader
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  fixed                   sample,
    input  logic                   sample_last,
    output fixed [NUM_INPUTS-1:0]  inputs,
    output logic                   inputs_ready,
    input  logic                   outputs_ready,
    output logic                   busy,
    output logic                   frame_error,
    output logic [15:0]            frames_done
);

    localparam int                c_IDX_W    = $clog2(NUM_INPUTS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_INPUTS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_FILL = 2'd0;
    localparam logic [1:0] c_FIRE = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_index;
    logic [c_IDX_W-1:0]    w_index_nxt;
    fixed [NUM_INPUTS-1:0] r_inputs;
    logic                  r_inputs_ready;
    logic                  r_frame_error;
    logic                  w_frame_error_nxt;
    logic [15:0]           r_frames_done;
    logic [15:0]           w_frames_done_nxt;
    logic                  w_accept;
    logic                  w_at_last;

    assign w_accept  = sample_valid && (r_state == c_FILL);
    assign w_at_last = (r_index == c_LAST_IDX);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FILL: begin
                if (w_accept && w_at_last && sample_last) begin
                    w_state_nxt = c_FIRE;
                end
            end
            c_FIRE: begin
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (outputs_ready) begin
                    w_state_nxt = c_FILL;
                end
            end
            default: begin
                w_state_nxt = c_FILL;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_index_nxt       = r_index;
        w_frame_error_nxt = 1'b0;
        w_frames_done_nxt = r_frames_done;
        if (w_accept) begin
            if (!w_at_last && !sample_last) begin
                w_index_nxt = r_index + c_IDX_ONE;
            end else begin
                // Every frame boundary restarts the slot index; a last flag
                // that disagrees with the slot position is a framing error.
                w_index_nxt       = '0;
                w_frame_error_nxt = (w_at_last != sample_last);
            end
        end
        if ((r_state == c_WAIT) && outputs_ready) begin
            w_frames_done_nxt = r_frames_done + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_index        <= '0;
            r_inputs_ready <= 1'b0;
            r_frame_error  <= 1'b0;
            r_frames_done  <= '0;
        end else begin
            r_index        <= w_index_nxt;
            r_inputs_ready <= (w_state_nxt == c_FIRE);
            r_frame_error  <= w_frame_error_nxt;
            r_frames_done  <= w_frames_done_nxt;
        end
    end

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_slot
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_inputs[k] <= '0;
            end else if (w_accept && (r_index == c_IDX_W'(k))) begin
                r_inputs[k] <= sample;
            end
        end
    end

    assign sample_ready = (r_state == c_FILL);
    assign busy         = (r_state != c_FILL);
    assign inputs       = r_inputs;
    assign inputs_ready = r_inputs_ready;
    assign frame_error  = r_frame_error;
    assign frames_done  = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_network_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_network_input_loader                                   |
// | Purpose  : Table vectors, corner sequences and random frames checked |
// |            against a queue-based frame model.                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_network_input_loader;
    import nn_pkg::*;

    localparam int N  = 10;
    localparam int VW = N * 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    fixed         sample = '0;
    logic         sample_last = 1'b0;
    fixed [N-1:0] inputs;
    logic         inputs_ready;
    logic         outputs_ready = 1'b0;
    logic         busy;
    logic         frame_error;
    logic [15:0]  frames_done;

    network_input_loader #(.NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample       (sample),
        .sample_last  (sample_last),
        .inputs       (inputs),
        .inputs_ready (inputs_ready),
        .outputs_ready(outputs_ready),
        .busy         (busy),
        .frame_error  (frame_error),
        .frames_done  (frames_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame model: collected samples, presented vector, phase of the handshake
    logic [31:0] m_q[$];
    logic [31:0] m_vec[N];
    logic [15:0] m_frames;
    logic        m_fired, m_waiting, m_err;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] m_packed();
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) r[k*32 +: 32] = m_vec[k];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < N; k++) m_vec[k] = '0;
        m_frames = '0; m_fired = 0; m_waiting = 0; m_err = 0;
    endtask

    // Apply one clock edge of stimulus to the model.
    task automatic model_edge(input logic v, input logic [31:0] d, input logic l, input logic o);
        logic filling;
        filling = !m_fired && !m_waiting;
        m_err = 0;
        if (m_fired) begin
            m_fired = 0; m_waiting = 1;
        end else if (m_waiting) begin
            if (o) begin m_frames = m_frames + 16'd1; m_waiting = 0; end
        end
        if (filling && v) begin
            m_vec[m_q.size()] = d;
            m_q.push_back(d);
            if (l) begin
                if (m_q.size() == N) m_fired = 1; else m_err = 1;
                m_q.delete();
            end else if (m_q.size() == N) begin
                m_err = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_model();
        chk("sample_ready", VW'(sample_ready), VW'(!m_fired && !m_waiting));
        chk("inputs_ready", VW'(inputs_ready), VW'(m_fired));
        chk("busy", VW'(busy), VW'(m_fired || m_waiting));
        chk("frame_error", VW'(frame_error), VW'(m_err));
        chk("frames_done", VW'(frames_done), VW'(m_frames));
        chk("inputs", VW'(inputs), m_packed());
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic o);
        @(negedge clock);
        sample_valid = v; sample = d; sample_last = l; outputs_ready = o;
        @(posedge clock);
        model_edge(v, d, l, o);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        sample_valid = 0; outputs_ready = 0; sample_last = 0;
        #2 reset = 1'b0;
        #1;
        chk("rst_sample_ready", VW'(sample_ready), VW'(1));
        chk("rst_inputs_ready", VW'(inputs_ready), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_frame_error", VW'(frame_error), VW'(0));
        chk("rst_frames_done", VW'(frames_done), VW'(0));
        chk("rst_inputs", VW'(inputs), '0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic send_frame(input int base, input int cnt, input logic last_on_final);
        for (int i = 0; i < cnt; i++)
            step(1, 32'((base + i) << 16), (i == cnt - 1) ? last_on_final : 1'b0, 0);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        o;
        logic        e_srdy;
        logic        e_irdy;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_frames;
    } vec_t;

    vec_t tbl[17];
    logic [VW-1:0] nominal_vec;

    initial begin
        // Nominal frame: 1.0..10.0, stale completion in FIRE, real one 5 cycles later
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1, 32'((i + 1) << 16), (i == 9), 0, (i != 9), (i == 9), (i == 9), 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        for (int i = 11; i < 15; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
        for (int k = 0; k < N; k++) nominal_vec[k*32 +: 32] = 32'((k + 1) << 16);

        model_reset();
        repeat (2) @(posedge clock);
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
            chk("tbl_sample_ready", VW'(sample_ready), VW'(tbl[i].e_srdy));
            chk("tbl_inputs_ready", VW'(inputs_ready), VW'(tbl[i].e_irdy));
            chk("tbl_busy", VW'(busy), VW'(tbl[i].e_busy));
            chk("tbl_frame_error", VW'(frame_error), VW'(tbl[i].e_err));
            chk("tbl_frames_done", VW'(frames_done), VW'(tbl[i].e_frames));
        end
        chk("nominal_inputs", VW'(inputs), nominal_vec);

        // Short frame: last on the 4th sample, then a good frame
        send_frame(20, 4, 1'b1);
        chk("short_err", VW'(frame_error), VW'(1));
        chk("short_no_fire", VW'(inputs_ready), VW'(0));
        step(0, 0, 0, 0);
        chk("short_err_clear", VW'(frame_error), VW'(0));
        send_frame(40, 10, 1'b1);
        chk("after_short_fire", VW'(inputs_ready), VW'(1));
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("after_short_frames", VW'(frames_done), VW'(2));

        // Long frame: 10th sample without last
        send_frame(60, 10, 1'b0);
        chk("long_err", VW'(frame_error), VW'(1));
        chk("long_not_busy", VW'(busy), VW'(0));
        send_frame(1, 10, 1'b1);
        chk("long_restart_inputs", VW'(inputs), nominal_vec);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        // Random stalls, random data, occasional framing faults and completions
        for (int c = 0; c < 600; c++) begin
            logic v, l, o;
            v = ($urandom_range(0, 1) == 1);
            l = (m_q.size() == N - 1) ^ ($urandom_range(0, 24) == 0);
            o = ($urandom_range(0, 4) == 0);
            step(v, $urandom, l, o);
        end

        // Reset after 6 samples, then mid-WAIT, then a clean frame
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        while (m_q.size() != 0) step(1, $urandom, 1, 0);
        send_frame(3, 6, 1'b0);
        do_reset();
        send_frame(5, 10, 1'b1);
        step(0, 0, 0, 0);
        chk("pre_rst_wait_busy", VW'(busy), VW'(1));
        do_reset();
        send_frame(1, 10, 1'b1);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("clean_frames", VW'(frames_done), VW'(1));
        chk("clean_inputs", VW'(inputs), nominal_vec);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
